// File: rtl/pos_frame_ctrl_pkg.sv
// Shared types and constants for the position frame controller.
//   state_e      : controller state (OPEN, LOCKED, DRAIN)
//   sample_t     : one position sample plus the id of the source it came from
//   pack_status  : builds the status byte {new, overrun, src, 0, seq}
package pos_frame_pkg;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned STAT_W  = 8;

    localparam int unsigned ST_NEW  = 7;
    localparam int unsigned ST_OVR  = 6;
    localparam int unsigned ST_SRC  = 5;
    localparam int unsigned SEQ_MSB = 3;

    localparam logic SRC_TRACK   = 1'b0;
    localparam logic SRC_PATTERN = 1'b1;

    typedef enum logic [1:0] {
        OPEN   = 2'd0,
        LOCKED = 2'd1,
        DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               src;
    } sample_t;

    function automatic logic [STAT_W-1:0] pack_status(input logic new_data,
                                                      input logic overrun,
                                                      input logic src,
                                                      input logic [SEQ_W-1:0] seq);
        logic [STAT_W-1:0] s;
        s            = '0;
        s[ST_NEW]    = new_data;
        s[ST_OVR]    = overrun;
        s[ST_SRC]    = src;
        s[SEQ_MSB:0] = seq;
        return s;
    endfunction

endpackage

// File: rtl/pos_frame_ctrl_if.sv
// Bus bundle between the position sources / I2C slave and the frame controller.
//   master : environment side (drives samples and read pulses)
//   slave  : controller side (drives ready, frame bytes, lock status)
interface pos_frame_ctrl_if import pos_frame_pkg::*;;

    logic               s0_valid;
    logic               s0_ready;
    logic [COORD_W-1:0] s0_x;
    logic [COORD_W-1:0] s0_y;
    logic               s1_valid;
    logic               s1_ready;
    logic [COORD_W-1:0] s1_x;
    logic [COORD_W-1:0] s1_y;
    logic               rd_start;
    logic               rd_done;
    logic [COORD_W-1:0] x_pos;
    logic [COORD_W-1:0] y_pos;
    logic [STAT_W-1:0]  status;
    logic               locked;
    logic               timeout_evt;

    modport master (
        output s0_valid, s0_x, s0_y, s1_valid, s1_x, s1_y, rd_start, rd_done,
        input  s0_ready, s1_ready, x_pos, y_pos, status, locked, timeout_evt
    );

    modport slave (
        input  s0_valid, s0_x, s0_y, s1_valid, s1_x, s1_y, rd_start, rd_done,
        output s0_ready, s1_ready, x_pos, y_pos, status, locked, timeout_evt
    );

endinterface

// File: rtl/pos_frame_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter.
//   req   : request vector (bit 0 = source 0, bit 1 = source 1)
//   gnt_c : combinational one-hot grant
// The pointer only moves when both request, so a lone requester never
// steals the other's next turn.
module rr_arb2 import pos_frame_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update
    always_comb begin
        gnt_c = 2'b00;
        ptr_d = ptr_q;
        unique case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11: begin
                gnt_c = (ptr_q == SRC_PATTERN) ? 2'b10 : 2'b01;
                ptr_d = ~ptr_q;
            end
            default: gnt_c = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= SRC_TRACK;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/pos_frame_ctrl.sv
// Position frame controller: arbitrates two sample sources onto the
// x_pos/y_pos/status frame read by the I2C slave, freezes the frame during
// a read, buffers one pending sample and force-releases a stuck lock.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave modport (sample handshakes, rd_start/rd_done,
//                frame bytes, locked, timeout_evt)
module pos_frame_ctrl import pos_frame_pkg::*; #(
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned TW           = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pos_frame_ctrl_if.slave       bus
);

    logic [1:0] gnt_c;
    logic       acc_c;
    sample_t    acc_s_c;

    state_e             state_q,    state_d;
    logic [COORD_W-1:0] x_q,        x_d;
    logic [COORD_W-1:0] y_q,        y_d;
    logic               new_q,      new_d;
    logic               ovr_q,      ovr_d;
    logic               src_q,      src_d;
    logic [SEQ_W-1:0]   seq_q,      seq_d;
    sample_t            pend_q,     pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               ovr_nxt_q,  ovr_nxt_d;
    logic               read_ok_q,  read_ok_d;
    logic [TW-1:0]      timer_q,    timer_d;
    logic               locked_q,   locked_d;
    logic               tevt_q,     tevt_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.s1_valid, bus.s0_valid}),
        .gnt_c (gnt_c)
    );

    // Accepted sample this cycle
    always_comb begin
        acc_c       = |gnt_c;
        acc_s_c.x   = gnt_c[1] ? bus.s1_x : bus.s0_x;
        acc_s_c.y   = gnt_c[1] ? bus.s1_y : bus.s0_y;
        acc_s_c.src = gnt_c[1] ? SRC_PATTERN : SRC_TRACK;
    end

    // Next-state, frame, pending and timer logic
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        new_d      = new_q;
        ovr_d      = ovr_q;
        src_d      = src_q;
        seq_d      = seq_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_nxt_d  = ovr_nxt_q;
        read_ok_d  = read_ok_q;
        timer_d    = timer_q;
        tevt_d     = 1'b0;

        unique case (state_q)
            OPEN: begin
                if (bus.rd_start) begin
                    // Lock wins: a simultaneous sample is parked in pending
                    state_d = LOCKED;
                    timer_d = '0;
                    if (acc_c) begin
                        pend_d     = acc_s_c;
                        pend_vld_d = 1'b1;
                        if (pend_vld_q) ovr_nxt_d = 1'b1;
                    end
                end else if (pend_vld_q) begin
                    // Sample parked during the drain cycle publishes first
                    x_d        = pend_q.x;
                    y_d        = pend_q.y;
                    src_d      = pend_q.src;
                    new_d      = 1'b1;
                    seq_d      = seq_q + SEQ_W'(1);
                    pend_vld_d = acc_c;
                    ovr_nxt_d  = 1'b0;
                    if (acc_c) pend_d = acc_s_c;
                end else if (acc_c) begin
                    x_d   = acc_s_c.x;
                    y_d   = acc_s_c.y;
                    src_d = acc_s_c.src;
                    new_d = 1'b1;
                    seq_d = seq_q + SEQ_W'(1);
                end
            end

            LOCKED: begin
                if (acc_c) begin
                    pend_d     = acc_s_c;
                    pend_vld_d = 1'b1;
                    if (pend_vld_q) ovr_nxt_d = 1'b1;
                end
                if (bus.rd_done) begin
                    state_d   = DRAIN;
                    read_ok_d = 1'b1;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    state_d   = DRAIN;
                    read_ok_d = 1'b0;
                    tevt_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            DRAIN: begin
                // Flags only clear after a confirmed read
                if (read_ok_q) begin
                    new_d = 1'b0;
                    ovr_d = 1'b0;
                end
                if (pend_vld_q) begin
                    x_d   = pend_q.x;
                    y_d   = pend_q.y;
                    src_d = pend_q.src;
                    new_d = 1'b1;
                    seq_d = seq_q + SEQ_W'(1);
                    ovr_d = (read_ok_q ? 1'b0 : ovr_q) | ovr_nxt_q;
                end
                pend_vld_d = acc_c;
                ovr_nxt_d  = 1'b0;
                if (acc_c) pend_d = acc_s_c;
                if (bus.rd_start) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else begin
                    state_d = OPEN;
                end
            end

            default: state_d = OPEN;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= OPEN;
            x_q        <= '0;
            y_q        <= '0;
            new_q      <= 1'b0;
            ovr_q      <= 1'b0;
            src_q      <= SRC_TRACK;
            seq_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_nxt_q  <= 1'b0;
            read_ok_q  <= 1'b0;
            timer_q    <= '0;
            locked_q   <= 1'b0;
            tevt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            new_q      <= new_d;
            ovr_q      <= ovr_d;
            src_q      <= src_d;
            seq_q      <= seq_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_nxt_q  <= ovr_nxt_d;
            read_ok_q  <= read_ok_d;
            timer_q    <= timer_d;
            locked_q   <= locked_d;
            tevt_q     <= tevt_d;
        end
    end

    assign bus.s0_ready    = gnt_c[0];
    assign bus.s1_ready    = gnt_c[1];
    assign bus.x_pos       = x_q;
    assign bus.y_pos       = y_q;
    assign bus.status      = pack_status(new_q, ovr_q, src_q, seq_q);
    assign bus.locked      = locked_q;
    assign bus.timeout_evt = tevt_q;

endmodule

// File: tb/tb_pos_frame_ctrl.sv
// Directed bench for pos_frame_ctrl with LOCK_TIMEOUT = 8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pos_frame_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    pos_frame_ctrl_if bus ();

    pos_frame_ctrl #(.LOCK_TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.s0_valid = 1'b0; bus.s0_x = '0; bus.s0_y = '0;
        bus.s1_valid = 1'b0; bus.s1_x = '0; bus.s1_y = '0;
        bus.rd_start = 1'b0; bus.rd_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_x",      32'(bus.x_pos),       32'h0);
        chk("rst_y",      32'(bus.y_pos),       32'h0);
        chk("rst_status", 32'(bus.status),      32'h0);
        chk("rst_locked", 32'(bus.locked),      32'h0);
        chk("rst_tevt",   32'(bus.timeout_evt), 32'h0);
        rst_n = 1'b1;

        // Single s0 sample in OPEN: visible one cycle later
        bus.s0_valid = 1'b1; bus.s0_x = 8'h12; bus.s0_y = 8'h34;
        #1;
        chk("s0_ready_hi", 32'(bus.s0_ready), 32'h1);
        chk("s1_ready_lo", 32'(bus.s1_ready), 32'h0);
        tick();
        bus.s0_valid = 1'b0;
        chk("one_x",      32'(bus.x_pos),  32'h12);
        chk("one_y",      32'(bus.y_pos),  32'h34);
        chk("one_status", 32'(bus.status), 32'h81);
        #1;
        chk("s0_ready_drop", 32'(bus.s0_ready), 32'h0);

        // Both sources valid from reset: round-robin s0, s1, s0, s1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.s0_valid = 1'b1; bus.s0_x = 8'hA0; bus.s0_y = 8'hA1;
        bus.s1_valid = 1'b1; bus.s1_x = 8'hB0; bus.s1_y = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_s0_ready", 32'(bus.s0_ready), 32'((i % 2) == 0));
            chk("rr_s1_ready", 32'(bus.s1_ready), 32'((i % 2) == 1));
            tick();
            chk("rr_status", 32'(bus.status), 32'h80 | ((i % 2) << 5) | (i + 1));
        end
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        chk("rr_x_last", 32'(bus.x_pos), 32'hB0);

        // Lock, three s1 samples overwrite pending, then confirmed read
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        chk("lk_locked", 32'(bus.locked), 32'h1);
        bus.s1_valid = 1'b1; bus.s1_x = 8'h01; bus.s1_y = 8'h02;
        tick();
        chk("lk_hold_x1", 32'(bus.x_pos), 32'hB0);
        bus.s1_x = 8'h03; bus.s1_y = 8'h04;
        tick();
        chk("lk_hold_x2", 32'(bus.x_pos), 32'hB0);
        bus.s1_x = 8'h05; bus.s1_y = 8'h06;
        tick();
        bus.s1_valid = 1'b0;
        chk("lk_hold_x3",   32'(bus.x_pos),  32'hB0);
        chk("lk_hold_stat", 32'(bus.status), 32'hA4);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        chk("drn_unlocked", 32'(bus.locked), 32'h0);
        chk("drn_x_old",    32'(bus.x_pos),  32'hB0);
        tick();
        chk("rel_x",      32'(bus.x_pos),  32'h05);
        chk("rel_y",      32'(bus.y_pos),  32'h06);
        chk("rel_status", 32'(bus.status), 32'hE5);

        // Lock abandoned: forced release after the 8th locked cycle
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("to_locked",   32'(bus.locked),      32'h1);
            chk("to_tevt_lo",  32'(bus.timeout_evt), 32'h0);
            tick();
        end
        chk("to_tevt_hi",   32'(bus.timeout_evt), 32'h1);
        chk("to_released",  32'(bus.locked),      32'h0);
        chk("to_status",    32'(bus.status),      32'hE5);
        tick();
        chk("to_tevt_pulse", 32'(bus.timeout_evt), 32'h0);
        chk("to_open",       32'(bus.locked),      32'h0);

        // rd_start and s0 sample together: lock wins, sample after read
        bus.rd_start = 1'b1;
        bus.s0_valid = 1'b1; bus.s0_x = 8'h77; bus.s0_y = 8'h88;
        tick();
        bus.rd_start = 1'b0;
        bus.s0_valid = 1'b0;
        chk("co_locked", 32'(bus.locked), 32'h1);
        chk("co_x_old",  32'(bus.x_pos),  32'h05);
        chk("co_stat",   32'(bus.status), 32'hE5);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        tick();
        chk("co_x_new",  32'(bus.x_pos),  32'h77);
        chk("co_y_new",  32'(bus.y_pos),  32'h88);
        chk("co_stat2",  32'(bus.status), 32'h86);

        // 16 loads: seq walks 7..15, wraps to 0, ends back at 6
        for (int i = 0; i < 16; i++) begin
            bus.s0_valid = 1'b1;
            bus.s0_x = 8'(i);
            bus.s0_y = 8'(255 - i);
            tick();
            chk("seq_status", 32'(bus.status), 32'h80 | ((7 + i) % 16));
        end
        bus.s0_valid = 1'b0;
        chk("seq_x_last", 32'(bus.x_pos), 32'h0F);

        // Reset while locked with pending full: everything discarded
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        bus.s1_valid = 1'b1; bus.s1_x = 8'hAA; bus.s1_y = 8'hBB;
        tick();
        bus.s1_valid = 1'b0;
        chk("mr_locked", 32'(bus.locked), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_x",      32'(bus.x_pos),       32'h0);
        chk("mr_y",      32'(bus.y_pos),       32'h0);
        chk("mr_status", 32'(bus.status),      32'h0);
        chk("mr_locked0", 32'(bus.locked),     32'h0);
        chk("mr_tevt",   32'(bus.timeout_evt), 32'h0);
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        tick();
        chk("mr_late_x",      32'(bus.x_pos),  32'h0);
        chk("mr_late_status", 32'(bus.status), 32'h0);
        chk("mr_late_locked", 32'(bus.locked), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
